// File: rtl/rv32_prefetch.sv
// RV32 instruction prefetch unit: credit-limited fetch requests, in-order response queue
// with per-entry PC, redirect discard of stale responses, and a stall/flush output stage.
module rv32_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic        instr_ready_in,
    input  logic        instr_read_valid_in,
    input  logic [31:0] instr_read_value_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned QW = AW + 1;
    // Back-to-back redirects can push in-flight beyond DEPTH; leave headroom.
    localparam int unsigned CW = AW + 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   pcf    [DEPTH];
    logic [AW-1:0] q_wr;
    logic [AW-1:0] q_rd;
    logic [QW-1:0] q_cnt;
    logic [AW-1:0] pcf_wr;
    logic [AW-1:0] pcf_rd;
    logic [AW-1:0] pcf_widx;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] credit_used;
    logic [31:0]   fetch_pc;

    logic accept;
    logic resp;
    logic drop;
    logic push;
    logic pop;

    assign credit_used       = CW'(q_cnt) + out_cnt;
    assign instr_read_out    = (credit_used < CW'(DEPTH)) || branch_taken_in;
    assign instr_address_out = branch_taken_in ? branch_pc_in : fetch_pc;

    assign accept = instr_read_out && instr_ready_in;
    assign resp   = instr_read_valid_in && (out_cnt != '0);
    assign drop   = resp && (branch_taken_in || (discard_cnt != '0));
    assign push   = resp && !drop;
    assign pop    = !stall_in && !flush_in && !branch_taken_in && (q_cnt != '0);

    // The PC FIFO only tracks requests whose responses will be kept; a redirect
    // restarts it with the target request in slot 0.
    assign pcf_widx = branch_taken_in ? '0 : pcf_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            out_cnt     <= '0;
            discard_cnt <= '0;
        end else begin
            if (accept)
                fetch_pc <= instr_address_out + 32'd4;
            else if (branch_taken_in)
                fetch_pc <= branch_pc_in;

            out_cnt <= out_cnt + CW'(accept) - CW'(resp);

            if (branch_taken_in)
                discard_cnt <= out_cnt - CW'(resp);
            else if (drop)
                discard_cnt <= discard_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcf_wr <= '0;
            pcf_rd <= '0;
        end else if (branch_taken_in) begin
            pcf_rd <= '0;
            pcf_wr <= accept ? AW'(1) : '0;
        end else begin
            if (accept)
                pcf_wr <= pcf_wr + 1'b1;
            if (push)
                pcf_rd <= pcf_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pcf[pcf_widx] <= instr_address_out;
        if (push) begin
            q_data[q_wr] <= instr_read_value_in;
            q_pc[q_wr]   <= pcf[pcf_rd];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else if (branch_taken_in) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (push)
                q_wr <= q_wr + 1'b1;
            if (pop)
                q_rd <= q_rd + 1'b1;
            q_cnt <= q_cnt + QW'(push) - QW'(pop);
        end
    end

    // Output stage: stall holds everything, otherwise either pop the head or insert a NOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_out       <= NOP;
            pc_out          <= '0;
            instr_valid_out <= 1'b0;
        end else if (!stall_in) begin
            if (pop) begin
                instr_out       <= q_data[q_rd];
                pc_out          <= q_pc[q_rd];
                instr_valid_out <= 1'b1;
            end else begin
                instr_out       <= NOP;
                instr_valid_out <= 1'b0;
            end
        end
    end

    resp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(instr_read_valid_in && (out_cnt == '0)));

    inflight_saturated: assert property (@(posedge clk) disable iff (reset)
        !(accept && !resp && (&out_cnt)));

    queue_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (q_cnt == QW'(DEPTH))));

endmodule

// File: tb/tb_rv32_prefetch.sv
// Bench for rv32_prefetch: in-order bus model plus an expected-instruction-stream scoreboard
// that is cleared on redirect and popped whenever a fresh valid instruction appears.
module tb_rv32_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic        branch_taken_in;
    logic [31:0] branch_pc_in;
    logic        instr_read_out;
    logic [31:0] instr_address_out;
    logic        instr_ready_in;
    logic        instr_read_valid_in;
    logic [31:0] instr_read_value_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid_out;

    rv32_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_in            (stall_in),
        .flush_in            (flush_in),
        .branch_taken_in     (branch_taken_in),
        .branch_pc_in        (branch_pc_in),
        .instr_read_out      (instr_read_out),
        .instr_address_out   (instr_address_out),
        .instr_ready_in      (instr_ready_in),
        .instr_read_valid_in (instr_read_valid_in),
        .instr_read_value_in (instr_read_value_in),
        .pc_out              (pc_out),
        .instr_out           (instr_out),
        .instr_valid_out     (instr_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } bus_t;

    exp_t sb[$];
    bus_t bus_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_accept = 0;
    int          n_valid = 0;
    int          first_valid_cyc = -1;
    logic [31:0] first_valid_pc = '0;
    bit          resp_en = 1'b0;
    int          lat = 1;
    logic [31:0] exp_fpc = RESET_PC;
    logic [31:0] last_pc = '0;
    logic [31:0] last_instr = NOP;
    logic        last_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: record the request/response handshake, clock, check the output stage,
    // then set up the bus response for the next cycle.
    task automatic tick();
        logic [31:0] exp_addr;
        bus_t        b;
        exp_t        e;
        bit          acc, st, fl, br;
        #2;
        st = stall_in;
        fl = flush_in;
        br = branch_taken_in;
        exp_addr = br ? branch_pc_in : exp_fpc;
        acc = instr_read_out && instr_ready_in;
        if (instr_read_valid_in && bus_q.size() > 0)
            void'(bus_q.pop_front());
        if (br)
            sb.delete();
        if (acc) begin
            check_val("req_addr", instr_address_out, exp_addr);
            b.addr = instr_address_out;
            b.cyc  = cyc;
            bus_q.push_back(b);
            e.pc    = exp_addr;
            e.instr = mem_word(exp_addr);
            sb.push_back(e);
            exp_fpc = exp_addr + 32'd4;
            n_accept++;
        end else if (br) begin
            exp_fpc = branch_pc_in;
        end

        @(posedge clk);
        #1;
        cyc++;

        if (st) begin
            check_val("stall_pc", pc_out, last_pc);
            check_val("stall_instr", instr_out, last_instr);
            check_val("stall_valid", 32'(instr_valid_out), 32'(last_valid));
        end else if (fl || br) begin
            check_val("nop_valid", 32'(instr_valid_out), 32'd0);
            check_val("nop_instr", instr_out, NOP);
            check_val("nop_pc_hold", pc_out, last_pc);
            last_valid = 1'b0;
            last_instr = NOP;
        end else if (instr_valid_out) begin
            n_valid++;
            if (first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                first_valid_pc  = pc_out;
            end
            if (sb.size() == 0) begin
                check_val("out_unexpected", 32'(instr_valid_out), 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("out_pc", pc_out, e.pc);
                check_val("out_instr", instr_out, e.instr);
                last_pc    = e.pc;
                last_instr = e.instr;
                last_valid = 1'b1;
            end
        end else begin
            check_val("empty_instr", instr_out, NOP);
            check_val("empty_pc_hold", pc_out, last_pc);
            last_valid = 1'b0;
            last_instr = NOP;
        end

        if (resp_en && bus_q.size() > 0 && (cyc - bus_q[0].cyc) >= lat) begin
            instr_read_valid_in = 1'b1;
            instr_read_value_in = mem_word(bus_q[0].addr);
        end else begin
            instr_read_valid_in = 1'b0;
            instr_read_value_in = $urandom;
        end
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        stall_in            = 1'b0;
        flush_in            = 1'b0;
        branch_taken_in     = 1'b0;
        instr_ready_in      = 1'b0;
        instr_read_valid_in = 1'b0;
        #1;
        check_val("rst_pc", pc_out, 32'd0);
        check_val("rst_instr", instr_out, NOP);
        check_val("rst_valid", 32'(instr_valid_out), 32'd0);
        sb.delete();
        bus_q.delete();
        exp_fpc    = RESET_PC;
        last_pc    = '0;
        last_instr = NOP;
        last_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("post_rst_addr", instr_address_out, RESET_PC);
        check_val("post_rst_read", 32'(instr_read_out), 32'd1);
    endtask

    task automatic drain(input string tag);
        stall_in        = 1'b0;
        flush_in        = 1'b0;
        branch_taken_in = 1'b0;
        instr_ready_in  = 1'b0;
        resp_en         = 1'b1;
        lat             = 1;
        for (int i = 0; i < 60 && (sb.size() > 0 || bus_q.size() > 0); i++)
            tick();
        tick();
        check_val({tag, "_drain_sb"}, 32'(sb.size()), 32'd0);
        check_val({tag, "_drain_bus"}, 32'(bus_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0, v0;
        logic [31:0] r;
        reset               = 1'b0;
        stall_in            = 1'b0;
        flush_in            = 1'b0;
        branch_taken_in     = 1'b0;
        branch_pc_in        = '0;
        instr_ready_in      = 1'b0;
        instr_read_valid_in = 1'b0;
        instr_read_value_in = '0;
        #1;
        do_reset();

        // Sequential fetch, 1-cycle latency
        resp_en = 1'b1;
        lat = 1;
        instr_ready_in = 1'b1;
        first_valid_cyc = -1;
        s0 = cyc;
        repeat (25) tick();
        check_val("seq_first_latency", 32'(first_valid_cyc - s0), 32'd3);
        v0 = n_valid;
        repeat (20) tick();
        check_val("seq_stream", 32'(n_valid - v0), 32'd20);
        drain("seq");

        // Credit limit with responses withheld
        do_reset();
        resp_en = 1'b0;
        instr_ready_in = 1'b1;
        a0 = n_accept;
        repeat (8) tick();
        check_val("credit_accepts", 32'(n_accept - a0), 32'd4);
        check_val("credit_read_low", 32'(instr_read_out), 32'd0);
        resp_en = 1'b1;
        for (int i = 0; i < 10 && !instr_read_out; i++)
            tick();
        check_val("credit_reopen", 32'(instr_read_out), 32'd1);
        drain("credit");

        // Redirect with three requests in flight
        do_reset();
        resp_en = 1'b0;
        instr_ready_in = 1'b1;
        repeat (3) tick();
        instr_ready_in = 1'b0;
        tick();
        branch_taken_in = 1'b1;
        branch_pc_in = 32'h0000_0100;
        instr_ready_in = 1'b1;
        tick();
        branch_taken_in = 1'b0;
        instr_ready_in = 1'b0;
        resp_en = 1'b1;
        first_valid_cyc = -1;
        v0 = n_valid;
        repeat (10) tick();
        check_val("redirect_first_pc", first_valid_pc, 32'h0000_0100);
        check_val("redirect_outputs", 32'(n_valid - v0), 32'd1);
        drain("redirect");

        // Stall with a full queue, then a one-cycle flush
        do_reset();
        resp_en = 1'b1;
        lat = 1;
        instr_ready_in = 1'b1;
        repeat (6) tick();
        stall_in = 1'b1;
        repeat (11) tick();
        check_val("stall_full_read_low", 32'(instr_read_out), 32'd0);
        stall_in = 1'b0;
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        repeat (10) tick();
        drain("stall");

        // Randomised traffic: wrap of both queues, stalls, flushes, redirects
        do_reset();
        v0 = n_valid;
        for (int i = 0; i < 300; i++) begin
            instr_ready_in  = ($urandom_range(0, 3) != 0);
            resp_en         = ($urandom_range(0, 2) != 0);
            stall_in        = ($urandom_range(0, 4) == 0);
            flush_in        = ($urandom_range(0, 7) == 0);
            branch_taken_in = ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 255);
            branch_pc_in    = r << 2;
            tick();
        end
        drain("rand");
        check_val("rand_volume", 32'(n_valid - v0 >= 20), 32'd1);

        // fetch_pc wrap at the top of the address space, then reset mid-stream
        do_reset();
        resp_en = 1'b1;
        lat = 1;
        instr_ready_in = 1'b1;
        branch_taken_in = 1'b1;
        branch_pc_in = 32'hFFFF_FFF8;
        tick();
        branch_taken_in = 1'b0;
        repeat (6) tick();
        check_val("wrap_fetch_pc", exp_fpc, 32'h0000_0014);
        do_reset();
        instr_ready_in = 1'b1;
        repeat (8) tick();
        drain("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
